reorder_buffer: RTL

//  In-order commit buffer between rename/dispatch and the reservation station/FUs.

---
 rtl/reorder_buffer_if.sv | 69 ++++++
 rtl/reorder_buffer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / FU / retire signal bundle for reorder_buffer.
// The flush input exists only when ROB_FLUSH_EN is defined.
interface reorder_buffer_if #(
  parameter int IDX_W  = 6,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
);
  logic              alloc_valid;
  logic              alloc_reg_write;
  logic [AREG_W-1:0] alloc_arch_rd;
  logic [PREG_W-1:0] alloc_phys_rd;
  logic [PREG_W-1:0] alloc_old_phys_rd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_rob_num;

  logic              cmpl_valid_0;
  logic              cmpl_valid_1;
  logic              cmpl_valid_2;
  logic [IDX_W-1:0]  cmpl_rob_0;
  logic [IDX_W-1:0]  cmpl_rob_1;
  logic [IDX_W-1:0]  cmpl_rob_2;
  logic [31:0]       cmpl_value_0;
  logic [31:0]       cmpl_value_1;
  logic [31:0]       cmpl_value_2;

  logic              retire_valid;
  logic              retire_reg_write;
  logic [AREG_W-1:0] retire_arch_rd;
  logic [PREG_W-1:0] retire_phys_rd;
  logic [PREG_W-1:0] retire_free_preg;
  logic [31:0]       retire_value;

  logic [IDX_W:0]    rob_count;
  logic              rob_empty;

`ifdef ROB_FLUSH_EN
  logic              flush;
`endif

  // Handshake: an allocation is accepted on a rising edge where
  // alloc_valid && alloc_ready; alloc_rob_num names the entry it lands in.
  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output alloc_valid, alloc_reg_write, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd,
    output cmpl_valid_0, cmpl_valid_1, cmpl_valid_2,
    output cmpl_rob_0, cmpl_rob_1, cmpl_rob_2,
    output cmpl_value_0, cmpl_value_1, cmpl_value_2,
    input  alloc_ready, alloc_rob_num,
    input  retire_valid, retire_reg_write, retire_arch_rd, retire_phys_rd,
    input  retire_free_preg, retire_value,
    input  rob_count, rob_empty
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  alloc_valid, alloc_reg_write, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd,
    input  cmpl_valid_0, cmpl_valid_1, cmpl_valid_2,
    input  cmpl_rob_0, cmpl_rob_1, cmpl_rob_2,
    input  cmpl_value_0, cmpl_value_1, cmpl_value_2,
    output alloc_ready, alloc_rob_num,
    output retire_valid, retire_reg_write, retire_arch_rd, retire_phys_rd,
    output retire_free_preg, retire_value,
    output rob_count, rob_empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates at tail, collects three FU results, retires one per cycle from head.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer #(
  parameter int ROB_SIZE = 64,
  parameter int IDX_W    = 6,
  parameter int PREG_W   = 6,
  parameter int AREG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);
  localparam int NUM_FU = 3;
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

  logic [ROB_SIZE-1:0] ent_valid;
  logic [ROB_SIZE-1:0] ent_done;
  logic [ROB_SIZE-1:0] ent_reg_write;
  logic [AREG_W-1:0]   ent_arch_rd  [ROB_SIZE];
  logic [PREG_W-1:0]   ent_phys_rd  [ROB_SIZE];
  logic [PREG_W-1:0]   ent_old_phys [ROB_SIZE];
  logic [31:0]         ent_value    [ROB_SIZE];

  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic                flush_now;
  logic                ready_int;
  logic                alloc_fire;
  logic                retire_fire;

  logic                cmpl_v   [NUM_FU];
  logic [IDX_W-1:0]    cmpl_idx [NUM_FU];
  logic [31:0]         cmpl_val [NUM_FU];
  logic                cmpl_hit [NUM_FU];

`ifdef ROB_FLUSH_EN
  assign flush_now = rob.flush;
`else
  assign flush_now = 1'b0;
`endif

  assign cmpl_v[0]   = rob.cmpl_valid_0;
  assign cmpl_v[1]   = rob.cmpl_valid_1;
  assign cmpl_v[2]   = rob.cmpl_valid_2;
  assign cmpl_idx[0] = rob.cmpl_rob_0;
  assign cmpl_idx[1] = rob.cmpl_rob_1;
  assign cmpl_idx[2] = rob.cmpl_rob_2;
  assign cmpl_val[0] = rob.cmpl_value_0;
  assign cmpl_val[1] = rob.cmpl_value_1;
  assign cmpl_val[2] = rob.cmpl_value_2;

  // Results aimed at entries that are not in flight are dropped.
  always_comb begin
    for (int p = 0; p < NUM_FU; p++) begin
      cmpl_hit[p] = cmpl_v[p] && ent_valid[cmpl_idx[p]];
    end
  end

  // Full uses the pre-edge count; a retire in the same cycle does not free a slot early.
  assign ready_int   = (count != FULL_CNT) && !flush_now;
  assign alloc_fire  = rob.alloc_valid && ready_int;
  assign retire_fire = ent_valid[head] && ent_done[head];

  assign rob.alloc_ready   = ready_int;
  assign rob.alloc_rob_num = tail;
  assign rob.rob_count     = count;
  assign rob.rob_empty     = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid            <= '0;
      ent_done             <= '0;
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      rob.retire_valid     <= 1'b0;
      rob.retire_reg_write <= 1'b0;
      rob.retire_arch_rd   <= '0;
      rob.retire_phys_rd   <= '0;
      rob.retire_free_preg <= '0;
      rob.retire_value     <= '0;
    end else if (flush_now) begin
      ent_valid        <= '0;
      ent_done         <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      rob.retire_valid <= 1'b0;
    end else begin
      rob.retire_valid <= retire_fire;
      for (int p = 0; p < NUM_FU; p++) begin
        if (cmpl_hit[p]) ent_done[cmpl_idx[p]] <= 1'b1;
      end
      // Retire clears after completions so a late result cannot revive a retired slot.
      if (retire_fire) begin
        ent_valid[head]      <= 1'b0;
        ent_done[head]       <= 1'b0;
        rob.retire_reg_write <= ent_reg_write[head];
        rob.retire_arch_rd   <= ent_arch_rd[head];
        rob.retire_phys_rd   <= ent_phys_rd[head];
        rob.retire_free_preg <= ent_old_phys[head];
        rob.retire_value     <= ent_value[head];
        head                 <= head + IDX_W'(1);
      end
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + IDX_W'(1);
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
    end
  end

  // Payload storage needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_reg_write[tail] <= rob.alloc_reg_write;
      ent_arch_rd[tail]   <= rob.alloc_arch_rd;
      ent_phys_rd[tail]   <= rob.alloc_phys_rd;
      ent_old_phys[tail]  <= rob.alloc_old_phys_rd;
    end
    // Descending order so the lowest-numbered port wins an index collision.
    for (int p = NUM_FU - 1; p >= 0; p--) begin
      if (cmpl_hit[p]) ent_value[cmpl_idx[p]] <= cmpl_val[p];
    end
  end
endmodule
